cascade_timer: RTL

CASCADE_TIMER -- requirements
Module: cascade_timer

---
 rtl/timer_pkg.sv | 23 ++
 rtl/cascade_timer_if.sv | 46 ++++
 rtl/timer_digit.sv | 65 ++++++
 rtl/cascade_timer.sv | 82 ++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the cascaded digit timer: default digit width,
// common per-digit terminal-value presets and a small clamp helper.
package timer_pkg;

    // Default width of one digit stage (BCD-sized).
    localparam int DEFAULT_DIGIT_W = 4;

    // Per-digit terminal values for a minutes:seconds display, digit 0 in the
    // low nibble: seconds-ones 9, seconds-tens 5, minutes-ones 9, minutes-tens 5.
    localparam logic [15:0] MMSS_MAX = 16'h5959;

    // Per-digit terminal values for an hours:minutes display.  Digits cascade
    // independently, so the hours-ones digit must be allowed to reach 9
    // (hours 00-29); a true 24-hour rollover needs extra logic outside.
    localparam logic [15:0] HHMM_MAX = 16'h2959;

    // Saturate a loaded digit value to its terminal value.
    function automatic int unsigned clamp_digit(input int unsigned value,
                                                input int unsigned max_value);
        return (value > max_value) ? max_value : value;
    endfunction

endpackage

// File: rtl/cascade_timer_if.sv
// Control/status bundle of the cascaded digit timer.  The controlling side
// (master) drives the count controls and watches the digit outputs; the
// timer itself takes the slave view.
interface cascade_timer_if
    import timer_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = DEFAULT_DIGIT_W
);
    logic                        tick;
    logic                        pause;
    logic                        up;
    logic                        stop_at_zero;
    logic                        load;
    logic [DIGITS*DIGIT_W-1:0]   load_value;
    logic [DIGITS*DIGIT_W-1:0]   count;
    logic [DIGITS-1:0]           digit_clk;
    logic                        wrap;
    logic                        zero;

    modport master (
        output tick,
        output pause,
        output up,
        output stop_at_zero,
        output load,
        output load_value,
        input  count,
        input  digit_clk,
        input  wrap,
        input  zero
    );

    modport slave (
        input  tick,
        input  pause,
        input  up,
        input  stop_at_zero,
        input  load,
        input  load_value,
        output count,
        output digit_clk,
        output wrap,
        output zero
    );
endinterface

// File: rtl/timer_digit.sv
// One stage of the cascade: a modulo-(MAX+1) up/down digit with a clamped
// synchronous load and a registered "upper half" flag used as a divided clock.
module timer_digit
    import timer_pkg::*;
#(
    parameter int                 DIGIT_W = DEFAULT_DIGIT_W,
    parameter logic [DIGIT_W-1:0] MAX     = DIGIT_W'(9)
) (
    input  logic               clk,
    input  logic               nReset,
    input  logic               en,
    input  logic               up,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    output logic [DIGIT_W-1:0] value,
    output logic               at_max,
    output logic               at_zero,
    output logic               half
);

    // Threshold above which the divided clock is high: floor(MAX/2).
    localparam logic [DIGIT_W-1:0] HALF_POINT = MAX >> 1;

    logic [DIGIT_W-1:0] value_reg;
    logic [DIGIT_W-1:0] value_next;
    logic               half_reg;
    logic               half_next;

    // Next digit value: load (clamped) has priority, otherwise step when enabled.
    always_comb begin
        value_next = value_reg;
        if (load) begin
            value_next = DIGIT_W'(clamp_digit(int'(load_val), int'(MAX)));
        end else if (en) begin
            if (up) begin
                value_next = (value_reg == MAX) ? '0 : value_reg + DIGIT_W'(1);
            end else begin
                value_next = (value_reg == '0) ? MAX : value_reg - DIGIT_W'(1);
            end
        end
    end

    // The divided clock is decoded from the next value so it changes on the
    // same edge as the digit and never sees the inputs combinationally.
    always_comb begin
        half_next = (value_next > HALF_POINT);
    end

    // Digit and divided-clock registers, cleared asynchronously.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            value_reg <= '0;
            half_reg  <= 1'b0;
        end else begin
            value_reg <= value_next;
            half_reg  <= half_next;
        end
    end

    assign value   = value_reg;
    assign half    = half_reg;
    assign at_max  = (value_reg == MAX);
    assign at_zero = (value_reg == '0);

endmodule

// File: rtl/cascade_timer.sv
// Cascaded multi-digit up/down timer.  Each digit is a timer_digit stage;
// the carry/borrow enable chain and the full-counter wrap flag live here.
module cascade_timer
    import timer_pkg::*;
#(
    parameter int                        DIGITS  = 4,
    parameter int                        DIGIT_W = DEFAULT_DIGIT_W,
    parameter logic [DIGITS*DIGIT_W-1:0] MAX_VEC = MMSS_MAX
) (
    input  logic            clk,
    input  logic            nReset,
    cascade_timer_if.slave  bus
);

    logic [DIGITS-1:0]         en;
    logic [DIGITS-1:0]         at_max;
    logic [DIGITS-1:0]         at_zero;
    logic [DIGITS-1:0]         ripple;
    logic [DIGITS-1:0]         half;
    logic [DIGITS*DIGIT_W-1:0] count_w;
    logic                      all_zero;
    logic                      hold_zero;
    logic                      step;
    logic                      top_wrap;
    logic                      wrap_reg;

    assign all_zero = &at_zero;

    // In down mode with stop_at_zero the counter parks at all-zero.
    assign hold_zero = !bus.up && bus.stop_at_zero && all_zero;

    // Load overrides pause, pause overrides tick.
    assign step = bus.tick && !bus.pause && !bus.load && !hold_zero;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            // A digit passes the step upward when it is about to roll over.
            assign ripple[gi] = bus.up ? at_max[gi] : at_zero[gi];

            if (gi == 0) begin : g_lsd
                assign en[gi] = step;
            end else begin : g_upper
                assign en[gi] = en[gi-1] && ripple[gi-1];
            end

            timer_digit #(
                .DIGIT_W (DIGIT_W),
                .MAX     (MAX_VEC[gi*DIGIT_W +: DIGIT_W])
            ) u_digit (
                .clk      (clk),
                .nReset   (nReset),
                .en       (en[gi]),
                .up       (bus.up),
                .load     (bus.load),
                .load_val (bus.load_value[gi*DIGIT_W +: DIGIT_W]),
                .value    (count_w[gi*DIGIT_W +: DIGIT_W]),
                .at_max   (at_max[gi]),
                .at_zero  (at_zero[gi]),
                .half     (half[gi])
            );
        end
    endgenerate

    // The whole counter wraps exactly when the top digit steps and rolls over.
    assign top_wrap = en[DIGITS-1] && ripple[DIGITS-1];

    // Wrap pulse register: high only for the cycle after a top-digit rollover.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wrap_reg <= 1'b0;
        end else begin
            wrap_reg <= top_wrap;
        end
    end

    assign bus.count     = count_w;
    assign bus.digit_clk = half;
    assign bus.wrap      = wrap_reg;
    assign bus.zero      = all_zero;

endmodule
